// File: rtl/draw_sequencer.sv
// Frame-draw controller: an optional full-screen clear, then erase-old/draw-new
// for the player and two blocks, emitting one registered pixel word per cycle.
module draw_sequencer #(
  parameter int unsigned SPR_W     = 4,
  parameter int unsigned SPR_H     = 4,
  parameter int unsigned SCR_W     = 160,
  parameter int unsigned SCR_H     = 120,
  parameter logic [2:0]  BG_COLOUR = 3'b000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic        clear_req,
  input  logic [7:0]  p_x,
  input  logic [6:0]  p_y,
  input  logic [2:0]  p_c,
  input  logic [7:0]  b0_x,
  input  logic [6:0]  b0_y,
  input  logic [2:0]  b0_c,
  input  logic [7:0]  b1_x,
  input  logic [6:0]  b1_y,
  input  logic [2:0]  b1_c,
  output logic [17:0] p_out,
  output logic [17:0] b_0_out,
  output logic [17:0] b_1_out,
  output logic [17:0] init_out,
  output logic [1:0]  draw_select,
  output logic        draw,
  output logic        busy,
  output logic        done,
  output logic        frame_miss
);

  typedef enum logic [3:0] {
    StIdle, StClear, StEraseP, StDrawP, StEraseB0, StDrawB0, StEraseB1, StDrawB1, StDone
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  cx_q, cx_d;
  logic [6:0]  cy_q, cy_d;
  logic        clear_pending_q, clear_pending_d;
  logic        skip_erase_q, skip_erase_d;
  logic [7:0]  new_x_q [3], new_x_d [3], old_x_q [3], old_x_d [3];
  logic [6:0]  new_y_q [3], new_y_d [3], old_y_q [3], old_y_d [3];
  logic [2:0]  new_c_q [3], new_c_d [3];
  logic [17:0] p_out_q, p_out_d, b_0_out_q, b_0_out_d, b_1_out_q, b_1_out_d;
  logic [17:0] init_out_q, init_out_d;
  logic [1:0]  sel_q, sel_d;
  logic        draw_q, draw_d, busy_q, busy_d, done_q, done_d, miss_q, miss_d;

  logic        last_x, last_y;
  logic [1:0]  obj_q, obj;
  logic [7:0]  base_x;
  logic [6:0]  base_y;
  logic [2:0]  colour;
  logic [8:0]  pix_x;
  logic [7:0]  pix_y;
  logic        on_screen;
  logic [17:0] word;

  function automatic logic [1:0] obj_of(state_e s);
    case (s)
      StEraseB0, StDrawB0: obj_of = 2'd1;
      StEraseB1, StDrawB1: obj_of = 2'd2;
      default:             obj_of = 2'd0;
    endcase
  endfunction

  function automatic logic is_draw(state_e s);
    is_draw = (s == StDrawP) || (s == StDrawB0) || (s == StDrawB1);
  endfunction

  // A clear frame overwrites everything, so the erase passes are skipped.
  function automatic state_e next_of(state_e s, logic skip);
    case (s)
      StClear, StEraseP: next_of = StDrawP;
      StDrawP:           next_of = skip ? StDrawB0 : StEraseB0;
      StEraseB0:         next_of = StDrawB0;
      StDrawB0:          next_of = skip ? StDrawB1 : StEraseB1;
      StEraseB1:         next_of = StDrawB1;
      StDrawB1:          next_of = StDone;
      default:           next_of = StIdle;
    endcase
  endfunction

  assign obj_q = obj_of(state_q);

  always_comb begin
    state_d         = state_q;
    cx_d            = cx_q;
    cy_d            = cy_q;
    skip_erase_d    = skip_erase_q;
    new_x_d         = new_x_q;
    new_y_d         = new_y_q;
    new_c_d         = new_c_q;
    old_x_d         = old_x_q;
    old_y_d         = old_y_q;
    clear_pending_d = clear_pending_q | clear_req;
    miss_d          = frame_tick && (state_q != StIdle);
    last_x = (state_q == StClear) ? (cx_q == 8'(SCR_W - 1)) : (cx_q == 8'(SPR_W - 1));
    last_y = (state_q == StClear) ? (cy_q == 7'(SCR_H - 1)) : (cy_q == 7'(SPR_H - 1));
    unique case (state_q)
      StIdle: begin
        if (frame_tick) begin
          new_x_d      = '{p_x, b0_x, b1_x};
          new_y_d      = '{p_y, b0_y, b1_y};
          new_c_d      = '{p_c, b0_c, b1_c};
          cx_d         = '0;
          cy_d         = '0;
          skip_erase_d = clear_pending_q;
          if (clear_pending_q) begin
            state_d         = StClear;
            clear_pending_d = clear_req;
          end else begin
            state_d = StEraseP;
          end
        end
      end
      StDone: state_d = StIdle;
      default: begin
        if (!last_x) begin
          cx_d = cx_q + 8'd1;
        end else begin
          cx_d = '0;
          if (!last_y) begin
            cy_d = cy_q + 7'd1;
          end else begin
            cy_d    = '0;
            state_d = next_of(state_q, skip_erase_q);
            if (is_draw(state_q)) begin
              old_x_d[obj_q] = new_x_q[obj_q];
              old_y_d[obj_q] = new_y_q[obj_q];
            end
          end
        end
      end
    endcase
  end

  // Output words are computed from the next state so they register on the same edge.
  always_comb begin
    obj    = obj_of(state_d);
    base_x = old_x_q[obj];
    base_y = old_y_q[obj];
    colour = BG_COLOUR;
    if (is_draw(state_d)) begin
      base_x = new_x_q[obj];
      base_y = new_y_q[obj];
      colour = new_c_q[obj];
    end else if (state_d == StClear) begin
      base_x = '0;
      base_y = '0;
    end
    pix_x      = {1'b0, base_x} + {1'b0, cx_d};
    pix_y      = {1'b0, base_y} + {1'b0, cy_d};
    on_screen  = (pix_x < 9'(SCR_W)) && (pix_y < 8'(SCR_H));
    word       = {pix_x[7:0], pix_y[6:0], colour};
    p_out_d    = '0;
    b_0_out_d  = '0;
    b_1_out_d  = '0;
    init_out_d = '0;
    sel_d      = 2'b00;
    draw_d     = 1'b0;
    busy_d     = (state_d != StIdle);
    done_d     = (state_d == StDone);
    if ((state_d != StIdle) && (state_d != StDone)) begin
      sel_d  = (state_d == StClear) ? 2'b11 : obj;
      draw_d = on_screen;
      if (on_screen) begin
        unique case (sel_d)
          2'b00: p_out_d    = word;
          2'b01: b_0_out_d  = word;
          2'b10: b_1_out_d  = word;
          2'b11: init_out_d = word;
        endcase
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= StIdle;
      cx_q            <= '0;
      cy_q            <= '0;
      clear_pending_q <= 1'b1;
      skip_erase_q    <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        new_x_q[i] <= '0;
        new_y_q[i] <= '0;
        new_c_q[i] <= '0;
        old_x_q[i] <= '0;
        old_y_q[i] <= '0;
      end
      p_out_q    <= '0;
      b_0_out_q  <= '0;
      b_1_out_q  <= '0;
      init_out_q <= '0;
      sel_q      <= '0;
      draw_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      miss_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      cx_q            <= cx_d;
      cy_q            <= cy_d;
      clear_pending_q <= clear_pending_d;
      skip_erase_q    <= skip_erase_d;
      new_x_q         <= new_x_d;
      new_y_q         <= new_y_d;
      new_c_q         <= new_c_d;
      old_x_q         <= old_x_d;
      old_y_q         <= old_y_d;
      p_out_q         <= p_out_d;
      b_0_out_q       <= b_0_out_d;
      b_1_out_q       <= b_1_out_d;
      init_out_q      <= init_out_d;
      sel_q           <= sel_d;
      draw_q          <= draw_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      miss_q          <= miss_d;
    end
  end

  assign p_out       = p_out_q;
  assign b_0_out     = b_0_out_q;
  assign b_1_out     = b_1_out_q;
  assign init_out    = init_out_q;
  assign draw_select = sel_q;
  assign draw        = draw_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign frame_miss  = miss_q;

endmodule
